// File: rtl/ccip_mmio_csr_rsp.sv
// AFU MMIO CSR responder: feature header, scratch/control/status registers and a queued read-completion path.
// Optional macro MMIO_CYCLE_COUNTER_EN adds the free-running CYCLE_CNT register at byte offset 0x40.
module ccip_mmio_csr_rsp #(
    parameter int          RDQ_DEPTH  = 4,
    parameter logic [63:0] AFU_DFH    = 64'h1000_0000_0000_1000,
    parameter logic [63:0] AFU_GUID_L = 64'h0,
    parameter logic [63:0] AFU_GUID_H = 64'h0
) (
    input  logic        pClk,
    input  logic        pck_cp2af_softReset_n,
    input  logic        mmio_rd_valid_i,
    input  logic        mmio_wr_valid_i,
    input  logic [15:0] mmio_addr_i,
    input  logic [1:0]  mmio_len_i,
    input  logic [8:0]  mmio_tid_i,
    input  logic [63:0] mmio_wdata_i,
    output logic        rsp_valid_o,
    output logic [8:0]  rsp_tid_o,
    output logic [63:0] rsp_data_o,
    input  logic        rsp_ready_i,
    output logic        ctrl_start_o,
    output logic        ctrl_enable_o,
    input  logic [31:0] status_i,
    output logic        rd_overflow_o
);

    localparam int PTR_W = $clog2(RDQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Register indices are 8-byte slots, i.e. the DWORD address with bit 0 dropped.
    localparam logic [14:0] IDX_DFH     = 15'd0;
    localparam logic [14:0] IDX_GUID_L  = 15'd1;
    localparam logic [14:0] IDX_GUID_H  = 15'd2;
    localparam logic [14:0] IDX_SCRATCH0 = 15'd4;
    localparam logic [14:0] IDX_SCRATCH1 = 15'd5;
    localparam logic [14:0] IDX_CTRL    = 15'd6;
    localparam logic [14:0] IDX_STATUS  = 15'd7;
    localparam logic [14:0] IDX_CYCLE   = 15'd8;

    typedef struct packed {
        logic [15:0] addr;
        logic [1:0]  len;
        logic [8:0]  tid;
    } rdq_entry_t;

    rdq_entry_t       rdq_mem [RDQ_DEPTH];
    rdq_entry_t       head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] rdq_count;
    logic             rdq_empty;
    logic             rdq_full;
    logic             load_rsp;
    logic             pop;
    logic             push;

    logic [63:0] scratch0;
    logic [63:0] scratch1;
    logic [14:0] wr_idx;
    logic [63:0] wr_mask;
    logic [63:0] wr_data;
    logic [14:0] rd_idx;
    logic [63:0] reg_val;
    logic [63:0] rd_data;

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [63:0] cycle_cnt;
`endif

    assign rdq_empty = (rdq_count == '0);
    assign rdq_full  = (rdq_count == CNT_W'(RDQ_DEPTH));
    assign load_rsp  = !rsp_valid_o || rsp_ready_i;
    assign pop       = !rdq_empty && load_rsp;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign push      = mmio_rd_valid_i && (!rdq_full || pop);
    assign head      = rdq_mem[rd_ptr];

    // 4B writes carry their data in the low DWORD and land in the half picked by addr[0].
    assign wr_idx  = mmio_addr_i[15:1];
    assign wr_data = (mmio_len_i == 2'd0) ? {2{mmio_wdata_i[31:0]}} : mmio_wdata_i;
    assign wr_mask = (mmio_len_i != 2'd0) ? 64'hFFFF_FFFF_FFFF_FFFF :
                     (mmio_addr_i[0]     ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_FFFF);

    always_ff @(posedge pClk) begin
        if (push) begin
            rdq_mem[wr_ptr] <= '{addr: mmio_addr_i, len: mmio_len_i, tid: mmio_tid_i};
        end
    end

    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rdq_count     <= '0;
            rd_overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   rdq_count <= rdq_count + CNT_W'(1);
                2'b01:   rdq_count <= rdq_count - CNT_W'(1);
                default: rdq_count <= rdq_count;
            endcase
            if (mmio_rd_valid_i && !push) rd_overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            scratch0      <= '0;
            scratch1      <= '0;
            ctrl_start_o  <= 1'b0;
            ctrl_enable_o <= 1'b0;
        end else begin
            ctrl_start_o <= 1'b0;
            if (mmio_wr_valid_i) begin
                case (wr_idx)
                    IDX_SCRATCH0: scratch0 <= (scratch0 & ~wr_mask) | (wr_data & wr_mask);
                    IDX_SCRATCH1: scratch1 <= (scratch1 & ~wr_mask) | (wr_data & wr_mask);
                    IDX_CTRL: begin
                        if (wr_mask[0]) ctrl_start_o  <= wr_data[0];
                        if (wr_mask[1]) ctrl_enable_o <= wr_data[1];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            cycle_cnt <= '0;
        end else if (mmio_wr_valid_i && (wr_idx == IDX_CYCLE)) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
        end
    end
`endif

    // Register contents are sampled here at pop time, so earlier writes are always visible.
    always_comb begin
        rd_idx  = head.addr[15:1];
        reg_val = '0;
        case (rd_idx)
            IDX_DFH:      reg_val = AFU_DFH;
            IDX_GUID_L:   reg_val = AFU_GUID_L;
            IDX_GUID_H:   reg_val = AFU_GUID_H;
            IDX_SCRATCH0: reg_val = scratch0;
            IDX_SCRATCH1: reg_val = scratch1;
            IDX_CTRL:     reg_val = {62'h0, ctrl_enable_o, 1'b0};
            IDX_STATUS:   reg_val = {32'h0, status_i};
`ifdef MMIO_CYCLE_COUNTER_EN
            IDX_CYCLE:    reg_val = cycle_cnt;
`endif
            default:      reg_val = '0;
        endcase
        if (head.len == 2'd0) begin
            rd_data = head.addr[0] ? {2{reg_val[63:32]}} : {2{reg_val[31:0]}};
        end else begin
            rd_data = reg_val;
        end
    end

    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            rsp_valid_o <= 1'b0;
            rsp_tid_o   <= '0;
            rsp_data_o  <= '0;
        end else if (load_rsp) begin
            rsp_valid_o <= !rdq_empty;
            if (pop) begin
                rsp_tid_o  <= head.tid;
                rsp_data_o <= rd_data;
            end
        end
    end

endmodule

// File: doc/ccip_mmio_csr_rsp.md
Name: ccip_mmio_csr_rsp

Overview:
- MMIO responder for the AFU CSR space.
- Accepts host MMIO read/write requests decoded from the registered CCI-P Rx c0 channel, which the host initiates.
- Holds the AFU feature header and control/status registers.
- Returns read completions toward the CCI-P Tx c2 channel through a small read queue with ready/valid backpressure from the Tx merge stage.

Parameters:
- RDQ_DEPTH, 4, read-request queue entries (power of 2, >=2).
- AFU_DFH, 64'h1000_0000_0000_1000, value returned at CSR 0x00.
- AFU_GUID_L, 64'h0, value returned at CSR 0x08.
- AFU_GUID_H, 64'h0, value returned at CSR 0x10.

Ports:
- pClk  in  1  CCI-P primary clock; only clock.
- pck_cp2af_softReset_n  in  1  synchronous active-low reset.
- mmio_rd_valid_i  in  1  MMIO read request this cycle.
- mmio_wr_valid_i  in  1  MMIO write request this cycle.
- mmio_addr_i  in  16  DWORD (4B) address.
- mmio_len_i  in  2  0=4B, 1=8B; 2/3 treated as 8B.
- mmio_tid_i  in  9  read transaction ID.
- mmio_wdata_i  in  64  write data.
- rsp_valid_o  out  1  read completion valid.
- rsp_tid_o  out  9  completion TID.
- rsp_data_o  out  64  completion data.
- rsp_ready_i  in  1  downstream accepts completion.
- ctrl_start_o  out  1  one-cycle start pulse.
- ctrl_enable_o  out  1  level enable.
- status_i  in  32  AFU status, sampled on read.
- rd_overflow_o  out  1  sticky: read dropped because queue full.

Behaviour:
- Reset (pClk edge with reset_n=0):
  - rsp_valid_o=0, rsp_tid_o=0, rsp_data_o=0, ctrl_start_o=0, ctrl_enable_o=0, rd_overflow_o=0.
  - SCRATCH0/1=0, CYCLE_CNT=0, queue emptied.
  - Reset mid-operation discards queued reads; no completion is issued for them.
- Register map (byte offset = addr*4; 64-bit regs at 8B-aligned offsets):
  - 0x00 DFH RO.
  - 0x08 GUID_L RO.
  - 0x10 GUID_H RO.
  - 0x20 SCRATCH0 RW.
  - 0x28 SCRATCH1 RW.
  - 0x30 CTRL: bit0 start, write-1 pulse, reads 0; bit1 enable RW; other bits read 0.
  - 0x38 STATUS RO: {32'h0, status_i}.
  - 0x40 CYCLE_CNT RO; any write clears it.
  - All other addresses read 0; writes to them are ignored.
- Writes:
  - Take effect at the next pClk edge.
  - 8B write: addr[0] ignored; full 64 bits.
  - 4B write: addr[0]=0 updates [31:0], addr[0]=1 updates [63:32]; the other half is unchanged.
  - A write to CTRL with bit0=1 drives ctrl_start_o=1 for exactly the following cycle.
- Reads:
  - {addr, len, tid} enqueued when mmio_rd_valid_i=1.
  - Register data is sampled when the entry is popped into the output register, not at enqueue. A write in the same or any earlier cycle is therefore visible to the read.
  - 4B read: selected 32-bit half replicated in both halves of rsp_data_o.
  - 8B read: full register.
- Output register:
  - Loads when empty or (rsp_valid_o & rsp_ready_i).
  - Holds rsp_valid_o/tid/data stable while rsp_valid_o=1 & rsp_ready_i=0.
  - Min latency 2 cycles, request to rsp_valid_o, with queue empty and ready high.
  - Sustains one completion per cycle under continuous ready.
- Queue full:
  - Read dropped; rd_overflow_o set; it stays set until reset.
  - If a pop occurs in the same cycle, the slot is freed first, so the read is accepted.
- Simultaneous rd+wr in one cycle: both processed; the read observes the written value.
- CYCLE_CNT:
  - Increments every cycle and wraps 2^64-1 -> 0.
  - A write clears it to 0 on the next edge; counting resumes the cycle after.

Optional Feature:
- Macro MMIO_CYCLE_COUNTER_EN.
  - Defined: CYCLE_CNT implemented as above.
  - Undefined: no counter logic; 0x40 reads 0; writes to 0x40 ignored.

Test Plan:
- Reset then 8B read addr 0x0000 tid 9'h05, ready=1 -> rsp_valid_o at cycle+2, tid 9'h05, data=AFU_DFH; all outputs 0 during reset.
- 8B write addr 0x0008 (SCRATCH0) data 64'hDEAD_BEEF_0123_4567; 4B write addr 0x0009 data 32'hCAFE_F00D; 8B read -> 64'hCAFE_F00D_0123_4567. 4B read addr 0x0008 -> 64'h0123_4567_0123_4567.
- Write CTRL (addr 0x000C) data 64'h3 -> ctrl_start_o high exactly one cycle and ctrl_enable_o=1. Read CTRL -> 64'h2.
- Hold rsp_ready_i=0, issue 6 reads tids 1..6 -> tid 1 held in the output register, 2..5 queued (RDQ_DEPTH=4), tid 6 dropped and rd_overflow_o=1. Release ready -> completions 1,2,3,4,5 in order on consecutive cycles, data/tid stable while stalled.
- Same cycle: write SCRATCH1 (addr 0x000A) 64'h1234 and 8B read addr 0x000A -> completion data 64'h1234.
- With MMIO_CYCLE_COUNTER_EN: write addr 0x0010, read it 10 cycles later -> value in 8..10 range per latency; read unmapped addr 0x0100 -> 0. Without macro: addr 0x0010 read -> 0.
